uart_tx_feeder: RTL

Upstream stage of the UART transmit path. Buffers bytes from a host-side write port in a FIFO and drives the UART's `data_in`/`txstart` pair, one byte per serial frame. Frames are paced with a `clk`-domain timer derived from the selected baud rate, so the transmitter never sees a new start while a frame is in flight. Sits between host logic and the UART top inside the same `clk` domain.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync_fifo.sv | 64 ++++++
 rtl/uart_tx_feeder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, baud-select encoding and feeder state type
package uart_pkg;

   localparam int FRAME_BITS = 11;
   localparam int GUARD_BITS = 1;

   localparam int DEF_DIV0 = 5208;
   localparam int DEF_DIV1 = 2604;
   localparam int DEF_DIV2 = 1302;
   localparam int DEF_DIV3 = 434;

   localparam logic [1:0] BAUD_SEL_0 = 2'b00;
   localparam logic [1:0] BAUD_SEL_1 = 2'b01;
   localparam logic [1:0] BAUD_SEL_2 = 2'b10;
   localparam logic [1:0] BAUD_SEL_3 = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      START,
      FRAME
   } tx_state_t;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - circular byte FIFO with registered count and overflow pulse
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_overflow;
   logic             w_push;
   logic             w_pop;

   assign full     = (r_count == FULL_CNT);
   assign empty    = (r_count == '0);
   assign count    = r_count;
   assign overflow = r_overflow;
   assign rd_data  = r_mem[r_rd_ptr];

   assign w_push = wr_en && !full;
   assign w_pop  = rd_en && !empty;

   // Storage is not reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // Full is judged on the registered count, so a same-cycle pop does not save the write.
         r_overflow <= wr_en && full;
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - FIFO-buffered byte feeder that paces txstart one frame at a time
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DIV0  = DEF_DIV0,
   parameter int DIV1  = DEF_DIV1,
   parameter int DIV2  = DEF_DIV2,
   parameter int DIV3  = DEF_DIV3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   input  logic [1:0]             baurd_sel,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic [7:0]             data_in,
   output logic                   txstart,
   output logic                   busy
);

   localparam int DIV_MAX = max4(DIV0, DIV1, DIV2, DIV3);
   localparam int CYC_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 2 + GUARD_BITS);

   tx_state_t        r_state;
   tx_state_t        w_state_nxt;
   logic [CYC_W-1:0] r_div_m1;
   logic [CYC_W-1:0] r_cyc;
   logic [CYC_W-1:0] w_sel_div_m1;
   logic [3:0]       r_bit;
   logic [7:0]       r_data;
   logic [7:0]       w_head;
   logic             w_pop;
   logic             w_cyc_done;

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (w_pop),
      .rd_data  (w_head),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   assign data_in    = r_data;
   assign w_cyc_done = (r_cyc == r_div_m1);

   // Divisor is stored minus one so a power-of-two maximum still fits the counter width.
   always_comb begin
      w_sel_div_m1 = CYC_W'(DIV3 - 1);
      case (baurd_sel)
         BAUD_SEL_0: w_sel_div_m1 = CYC_W'(DIV0 - 1);
         BAUD_SEL_1: w_sel_div_m1 = CYC_W'(DIV1 - 1);
         BAUD_SEL_2: w_sel_div_m1 = CYC_W'(DIV2 - 1);
         default:    w_sel_div_m1 = CYC_W'(DIV3 - 1);
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      txstart     = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            if (count != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            txstart = 1'b1;
            busy    = 1'b1;
            if (w_cyc_done) w_state_nxt = FRAME;
         end
         FRAME: begin
            busy = 1'b1;
            if (w_cyc_done && (r_bit == LAST_BIT)) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_data   <= 8'h00;
         r_div_m1 <= '0;
         r_cyc    <= '0;
         r_bit    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) begin
            r_data   <= w_head;
            r_div_m1 <= w_sel_div_m1;
            r_cyc    <= '0;
            r_bit    <= '0;
         end else if (r_state != IDLE) begin
            // Bit counter only advances in FRAME; START is a single bit period on its own.
            if (w_cyc_done) begin
               r_cyc <= '0;
               if (r_state == FRAME) r_bit <= r_bit + 1'b1;
            end else begin
               r_cyc <= r_cyc + 1'b1;
            end
         end
      end
   end

endmodule
